// File: rtl/ddmm_pkg.sv
// Shared types and constants for the day-of-year sequencer.
package ddmm_pkg;

  // Sequencer states: IDLE waits for keys, RUN auto-advances, LOAD is a one-cycle detour.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  // Last valid day of the Jan-Apr window in a non-leap year (31+28+31+30).
  localparam int DAY_MAX_STD = 120;

  // Width of one BCD digit.
  localparam int DIGIT_W = 4;

  // Bits needed to count 0 .. (clk_hz/step_hz - 1); never less than one bit.
  function automatic int presc_width(input int clk_hz, input int step_hz);
    int div;
    div = clk_hz / step_hz;
    if (div <= 1) begin
      return 1;
    end
    return $clog2(div);
  endfunction

endpackage

// File: rtl/ddmm_if.sv
// Switch/key inputs and converter-facing outputs of the day-of-year sequencer.
interface ddmm_if;
  import ddmm_pkg::*;

  logic [9:0]         SW;
  logic               key_step_n;
  logic               key_run_n;
  logic [DIGIT_W-1:0] MSB;
  logic [DIGIT_W-1:0] LSB;
  logic               leap_year;
  logic               running;
  logic               upd;
  logic               wrap;
  logic               load_err;

  // Board/parent side: drives switches and keys, observes the day.
  modport master (
    output SW, key_step_n, key_run_n,
    input  MSB, LSB, leap_year, running, upd, wrap, load_err
  );

  // Sequencer side.
  modport slave (
    input  SW, key_step_n, key_run_n,
    output MSB, LSB, leap_year, running, upd, wrap, load_err
  );

endinterface

// File: rtl/ddmm_sync_edge.sv
// Multi-stage synchronizer followed by a rising-edge pulse generator.
module ddmm_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] stage_reg;
  logic              prev_reg;

  // Shift the asynchronous level through the synchronizer chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  // Remember the previous synchronized level so a 0->1 change yields one pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= stage_reg[STAGES-1];
    end
  end

  assign rise = stage_reg[STAGES-1] & ~prev_reg;

endmodule

// File: rtl/ddmm_day_sequencer.sv
// Day-of-year counter (two BCD digits) for the Jan-Apr month/day converter:
// advanced by key or auto-run tick, loadable from switches, leap-aware wrap.
module ddmm_day_sequencer #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int STEP_HZ     = 4,
  parameter int DAY_MAX_STD = ddmm_pkg::DAY_MAX_STD,
  parameter int SYNC_STAGES = 2
) (
  input  logic   clock,
  input  logic   reset_n,
  ddmm_if.slave  bus
);
  import ddmm_pkg::state_t;
  import ddmm_pkg::IDLE;
  import ddmm_pkg::RUN;
  import ddmm_pkg::LOAD;
  import ddmm_pkg::DIGIT_W;
  import ddmm_pkg::presc_width;

  localparam int                 DIV       = CLK_HZ / STEP_HZ;
  localparam int                 PRESC_W   = presc_width(CLK_HZ, STEP_HZ);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [7:0]         DAY_CLAMP_HI = 8'(DAY_MAX_STD + 1);
  localparam logic [DIGIT_W-1:0] CLAMP_MSB = DIGIT_W'(DAY_MAX_STD / 10);
  localparam logic [DIGIT_W-1:0] CLAMP_LSB = DIGIT_W'(DAY_MAX_STD % 10);

  // Input conditioning
  logic       step_rise, run_rise, load_rise;
  logic [8:0] sw_pipe_reg [SYNC_STAGES];  // {SW[9], SW[7:0]}
  logic [8:0] sw_sync;
  logic [3:0] ld_tens, ld_ones;

  // State
  state_t               state_reg, state_next;
  state_t               ret_reg, ret_next;
  logic [PRESC_W-1:0]   presc_reg, presc_next;
  logic [DIGIT_W-1:0]   msb_reg, msb_next;
  logic [DIGIT_W-1:0]   lsb_reg, lsb_next;
  logic                 leap_reg;
  logic                 upd_reg, upd_next;
  logic                 wrap_reg, wrap_next;
  logic                 err_reg, err_next;

  // Derived values
  logic [7:0] day_cur, day_max, ld_value;
  logic       ld_ok, tick, clamp, at_max, advance;

  ddmm_sync_edge #(.STAGES(SYNC_STAGES)) u_step_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (~bus.key_step_n),
    .rise    (step_rise)
  );

  ddmm_sync_edge #(.STAGES(SYNC_STAGES)) u_run_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (~bus.key_run_n),
    .rise    (run_rise)
  );

  ddmm_sync_edge #(.STAGES(SYNC_STAGES)) u_load_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (bus.SW[8]),
    .rise    (load_rise)
  );

  // Plain synchronizer for leap flag and load value, same depth as the load edge path
  // so the value is aligned with its load pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_pipe_reg[i] <= '0;
      end
    end else begin
      sw_pipe_reg[0] <= {bus.SW[9], bus.SW[7:0]};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_pipe_reg[i] <= sw_pipe_reg[i-1];
      end
    end
  end

  assign sw_sync = sw_pipe_reg[SYNC_STAGES-1];
  assign ld_tens = sw_sync[7:4];
  assign ld_ones = sw_sync[3:0];

  assign day_cur  = {4'd0, msb_reg} * 8'd10 + {4'd0, lsb_reg};
  assign day_max  = 8'(DAY_MAX_STD) + {7'd0, leap_reg};
  assign ld_value = {4'd0, ld_tens} * 8'd10 + {4'd0, ld_ones};
  assign ld_ok    = (ld_ones <= 4'd9) && (ld_value >= 8'd1) && (ld_value <= day_max);
  assign tick     = (state_reg == RUN) && (presc_reg == PRESC_LAST);
  // Day 121 is only legal in a leap year; seen without the flag it must be pulled back.
  assign clamp    = !leap_reg && (day_cur == DAY_CLAMP_HI);
  assign at_max   = (day_cur >= day_max);
  assign advance  = (step_rise && (state_reg != LOAD)) || tick;

  // Next-state, prescaler and day update; events resolved as load > clamp > step > tick.
  always_comb begin
    state_next = state_reg;
    ret_next   = ret_reg;
    presc_next = presc_reg;
    msb_next   = msb_reg;
    lsb_next   = lsb_reg;
    upd_next   = 1'b0;
    wrap_next  = 1'b0;
    err_next   = err_reg;

    if (state_reg == RUN) begin
      presc_next = tick ? '0 : presc_reg + PRESC_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (load_rise) begin
          ret_next   = IDLE;
          state_next = LOAD;
        end else if (run_rise) begin
          state_next = RUN;
          presc_next = '0;
        end
      end
      RUN: begin
        if (load_rise) begin
          ret_next   = RUN;
          state_next = LOAD;
        end else if (run_rise) begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        if (!load_rise) begin
          state_next = ret_reg;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (load_rise) begin
      if (ld_ok) begin
        msb_next = ld_tens;
        lsb_next = ld_ones;
        err_next = 1'b0;
        upd_next = 1'b1;
      end else begin
        err_next = 1'b1;
      end
    end else if (clamp) begin
      msb_next = CLAMP_MSB;
      lsb_next = CLAMP_LSB;
      upd_next = 1'b1;
    end else if (advance) begin
      upd_next = 1'b1;
      if (at_max) begin
        msb_next  = '0;
        lsb_next  = DIGIT_W'(1);
        wrap_next = 1'b1;
      end else if (lsb_reg == 4'd9) begin
        lsb_next = '0;
        msb_next = msb_reg + DIGIT_W'(1);
      end else begin
        lsb_next = lsb_reg + DIGIT_W'(1);
      end
    end
  end

  // State, prescaler, day digits, leap copy and status pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      ret_reg   <= IDLE;
      presc_reg <= '0;
      msb_reg   <= '0;
      lsb_reg   <= DIGIT_W'(1);
      leap_reg  <= 1'b0;
      upd_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ret_reg   <= ret_next;
      presc_reg <= presc_next;
      msb_reg   <= msb_next;
      lsb_reg   <= lsb_next;
      leap_reg  <= sw_sync[8];
      upd_reg   <= upd_next;
      wrap_reg  <= wrap_next;
      err_reg   <= err_next;
    end
  end

  assign bus.MSB       = msb_reg;
  assign bus.LSB       = lsb_reg;
  assign bus.leap_year = leap_reg;
  assign bus.running   = (state_reg == RUN);
  assign bus.upd       = upd_reg;
  assign bus.wrap      = wrap_reg;
  assign bus.load_err  = err_reg;

endmodule

// File: tb/tb_ddmm_day_sequencer.sv
// Bench for the day-of-year sequencer: directed steps plus random step/load/leap
// traffic, checked against a day-number model (CLK_HZ=40, STEP_HZ=4).
module tb_ddmm_day_sequencer;

  logic clock = 1'b0;
  logic reset_n;

  ddmm_if bus ();

  ddmm_day_sequencer #(
    .CLK_HZ      (40),
    .STEP_HZ     (4),
    .DAY_MAX_STD (120),
    .SYNC_STAGES (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: day as a plain integer, leap flag, sticky error.
  int mday;
  int mleap;
  int merr;
  int upd_total;

  function automatic int dmax();
    return 120 + mleap;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check_day(input string tag);
    check({tag, "_msb"}, 32'(bus.MSB), mday / 10);
    check({tag, "_lsb"}, 32'(bus.LSB), mday % 10);
    check({tag, "_err"}, 32'(bus.load_err), merr);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_msb"}, 32'(bus.MSB), 0);
    check({tag, "_lsb"}, 32'(bus.LSB), 1);
    check({tag, "_leap"}, 32'(bus.leap_year), 0);
    check({tag, "_running"}, 32'(bus.running), 0);
    check({tag, "_upd"}, 32'(bus.upd), 0);
    check({tag, "_wrap"}, 32'(bus.wrap), 0);
    check({tag, "_err"}, 32'(bus.load_err), 0);
  endtask

  // One step press; upd/wrap must appear exactly on the third edge after the press.
  task automatic do_step(input string tag);
    int exp_wrap;
    exp_wrap = (mday == dmax()) ? 1 : 0;
    @(negedge clock);
    bus.key_step_n = 1'b0;
    @(negedge clock);
    bus.key_step_n = 1'b1;
    cyc();
    check({tag, "_upd_early"}, 32'(bus.upd), 0);
    cyc();
    mday = (exp_wrap == 1) ? 1 : mday + 1;
    check({tag, "_upd"}, 32'(bus.upd), 1);
    check({tag, "_wrap"}, 32'(bus.wrap), exp_wrap);
    if (bus.upd === 1'b1) upd_total++;
    cyc();
    check({tag, "_upd_late"}, 32'(bus.upd), 0);
    check_day(tag);
  endtask

  task automatic do_load(input int t, input int o, input string tag);
    int v;
    int ok;
    v  = t * 10 + o;
    ok = (o <= 9 && v >= 1 && v <= dmax()) ? 1 : 0;
    @(negedge clock);
    bus.SW[7:4] = t[3:0];
    bus.SW[3:0] = o[3:0];
    bus.SW[8]   = 1'b1;
    cyc();
    cyc();
    check({tag, "_upd_early"}, 32'(bus.upd), 0);
    cyc();
    if (ok == 1) begin
      mday = v;
      merr = 0;
    end else begin
      merr = 1;
    end
    check({tag, "_upd"}, 32'(bus.upd), ok);
    @(negedge clock);
    bus.SW[8] = 1'b0;
    repeat (3) cyc();
    check_day(tag);
  endtask

  task automatic set_leap(input int l);
    @(negedge clock);
    bus.SW[9] = l[0];
    repeat (6) cyc();
    if (mleap == 1 && l == 0 && mday == 121) mday = 120;
    mleap = l;
    check("leap_flag", 32'(bus.leap_year), l);
  endtask

  task automatic press_run();
    @(negedge clock);
    bus.key_run_n = 1'b0;
    @(negedge clock);
    bus.key_run_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int pos[$];
    int op;
    reset_n        = 1'b0;
    bus.SW         = '0;
    bus.key_step_n = 1'b1;
    bus.key_run_n  = 1'b1;
    mday = 1;
    mleap = 0;
    merr = 0;
    upd_total = 0;

    #12;
    check_reset("reset_hold");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) cyc();
    check_reset("after_release");

    // 1: nine steps, day 1 -> 10
    for (int i = 1; i <= 9; i++) do_step($sformatf("t1_step%0d", i));
    check("t1_upd_count", upd_total, 9);
    check("t1_final_msb", 32'(bus.MSB), 1);
    check("t1_final_lsb", 32'(bus.LSB), 0);

    // 2: wrap at 120 (non-leap), no wrap at 120 in a leap year
    do_load(12, 0, "t2_load120");
    do_step("t2_wrap_step");
    check("t2_wrapped_day", 32'(bus.LSB), 1);
    set_leap(1);
    do_load(12, 0, "t2_leap_load120");
    do_step("t2_leap_step");
    check("t2_day121_msb", 32'(bus.MSB), 12);
    check("t2_day121_lsb", 32'(bus.LSB), 1);

    // 3: load checking
    do_load(4, 10, "t3_bad_ones");
    do_load(0, 0, "t3_zero");
    do_load(13, 0, "t3_too_big");
    do_load(3, 1, "t3_day31");

    // 4: leap drop clamps 121 -> 120, then first auto-run tick wraps
    do_load(12, 1, "t4_load121");
    @(negedge clock);
    bus.SW[9] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (bus.upd === 1'b1) cnt++;
    end
    mleap = 0;
    mday = 120;
    check("t4_clamp_upd_count", cnt, 1);
    check_day("t4_clamp");
    press_run();
    cyc();
    cyc();
    check("t4_running", 32'(bus.running), 1);
    repeat (9) cyc();
    check("t4_pre_tick_msb", 32'(bus.MSB), 12);
    check("t4_pre_tick_lsb", 32'(bus.LSB), 0);
    cyc();
    mday = 1;
    check_day("t4_tick");
    check("t4_tick_wrap", 32'(bus.wrap), 1);
    check("t4_tick_upd", 32'(bus.upd), 1);

    // 5: auto-run spacing, then stop
    for (int i = 1; i <= 35; i++) begin
      cyc();
      if (bus.upd === 1'b1) pos.push_back(i);
    end
    check("t5_tick_count", pos.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t5_tick%0d_pos", k), (pos.size() > k) ? pos[k] : -1, 10 * (k + 1));
    end
    mday = mday + 3;
    check_day("t5_after_run");
    press_run();
    cyc();
    cyc();
    check("t5_stopped", 32'(bus.running), 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (bus.upd === 1'b1) cnt++;
    end
    check("t5_no_ticks", cnt, 0);
    check_day("t5_idle_day");

    // 6a: load edge and step press together: only the load counts
    @(negedge clock);
    bus.SW[7:0]    = 8'h55;
    bus.SW[8]      = 1'b1;
    bus.key_step_n = 1'b0;
    @(negedge clock);
    bus.key_step_n = 1'b1;
    cyc();
    cyc();
    mday = 55;
    merr = 0;
    check("t6_load_upd", 32'(bus.upd), 1);
    check_day("t6_load_wins");
    @(negedge clock);
    bus.SW[8] = 1'b0;
    repeat (4) cyc();
    check_day("t6_load_wins_later");

    // Random traffic against the model
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        do_step($sformatf("rnd%0d_step", n));
      end else if (op == 3) begin
        set_leap(1 - mleap);
        check_day($sformatf("rnd%0d_leap", n));
      end else begin
        do_load($urandom_range(0, 13), $urandom_range(0, 11), $sformatf("rnd%0d_load", n));
      end
    end

    // 6b: asynchronous reset in the middle of RUN
    do_load(0, 0, "t6_err_before_reset");
    set_leap(1);
    press_run();
    repeat (5) cyc();
    check("t6_running_before_reset", 32'(bus.running), 1);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset("t6_async_reset");
    @(negedge clock);
    bus.SW[9] = 1'b0;
    reset_n = 1'b1;
    repeat (20) cyc();
    check("t6_idle_after_reset", 32'(bus.running), 0);
    check("t6_day_after_reset", 32'(bus.LSB), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within 1 ms of sim time");
    $fatal(1, "timeout");
  end

endmodule
